// File: rtl/conv1_layer1_dense_addtree.sv
// conv1 layer1 dense adder tree: 25-lane product reduction, row accumulate,
// rescale and 16-bit saturate. CONV1_LAYER1_ADDTREE_RELU_EN enables ReLU.
module conv1_layer1_dense_addtree #(
  parameter int NUM_VEC   = 4,
  parameter int NUM_ROW   = 8,
  parameter int ACC_W     = 41,
  parameter int FRAC_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [799:0]      mult_res,
  input  logic              mult_res_v,
  output logic [15:0]       out_data,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_v,
  output logic              done,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t state_q;

  logic [31:0] lane [25];
  logic [32:0] l1_q [13];
  logic [33:0] l2_q [7];
  logic [34:0] l3_q [4];
  logic [35:0] l4_q [2];
  logic [36:0] l5_q;
  logic [4:0]  v_q;
  logic        in_v;

  logic [ACC_W-1:0] acc_q;
  logic [4:0]       vec_cnt_q;
  logic [7:0]       row_cnt_q;
  logic [15:0]      out_data_q;
  logic [ACC_W-1:0] out_acc_q;
  logic             out_v_q;
  logic             done_q;
  logic             busy_q;

  logic [ACC_W-1:0]        tree_ext;
  logic [ACC_W-1:0]        sum_d;
  logic signed [ACC_W-1:0] fin_s;
  logic signed [ACC_W-1:0] sh;
  logic [ACC_W-16:0]       hi;
  logic [15:0]             sat_d;
  logic                    last_vec;
  logic                    last_row;

  for (genvar k = 0; k < 25; k++) begin : g_lane
    assign lane[k] = mult_res[32*k +: 32];
  end

  // Vectors only enter the tree during a run; start drops the same-cycle vector.
  assign in_v = mult_res_v && (state_q == ACCUM) && !start;

  // Adder tree data path: sign-extend by one bit per level, odd element passes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 12; i++) begin
      l1_q[i] <= {lane[2*i][31], lane[2*i]}
               + {lane[2*i+1][31], lane[2*i+1]};
    end
    l1_q[12] <= {lane[24][31], lane[24]};
    for (int i = 0; i < 6; i++) begin
      l2_q[i] <= {l1_q[2*i][32], l1_q[2*i]}
               + {l1_q[2*i+1][32], l1_q[2*i+1]};
    end
    l2_q[6] <= {l1_q[12][32], l1_q[12]};
    for (int i = 0; i < 3; i++) begin
      l3_q[i] <= {l2_q[2*i][33], l2_q[2*i]}
               + {l2_q[2*i+1][33], l2_q[2*i+1]};
    end
    l3_q[3] <= {l2_q[6][33], l2_q[6]};
    for (int i = 0; i < 2; i++) begin
      l4_q[i] <= {l3_q[2*i][34], l3_q[2*i]}
               + {l3_q[2*i+1][34], l3_q[2*i+1]};
    end
    l5_q <= {l4_q[0][35], l4_q[0]} + {l4_q[1][35], l4_q[1]};
  end

  // Valid bits ride alongside the tree; start flushes everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
    end else if (start) begin
      v_q <= '0;
    end else begin
      v_q <= {v_q[3:0], in_v};
    end
  end

  assign tree_ext = {{(ACC_W-37){l5_q[36]}}, l5_q};
  assign sum_d    = acc_q + tree_ext;
  assign last_vec = (vec_cnt_q == 5'(NUM_VEC-1));
  assign last_row = (row_cnt_q == 8'(NUM_ROW-1));

  // Final sum conditioning: optional ReLU, shift, clamp to int16.
  always_comb begin
`ifdef CONV1_LAYER1_ADDTREE_RELU_EN
    fin_s = sum_d[ACC_W-1] ? '0 : $signed(sum_d);
`else
    fin_s = $signed(sum_d);
`endif
    sh = fin_s >>> FRAC_BITS;
    hi = sh[ACC_W-1:15];
    if ((&hi) || !(|hi)) begin
      sat_d = sh[15:0];
    end else if (sh[ACC_W-1]) begin
      sat_d = 16'h8000;
    end else begin
      sat_d = 16'h7fff;
    end
  end

  // Run control, accumulation and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      vec_cnt_q  <= '0;
      row_cnt_q  <= '0;
      out_data_q <= '0;
      out_acc_q  <= '0;
      out_v_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (start) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      vec_cnt_q <= '0;
      row_cnt_q <= '0;
      out_v_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      out_v_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
        end
        ACCUM: begin
          busy_q <= 1'b1;
          if (v_q[4]) begin
            if (last_vec) begin
              out_acc_q  <= fin_s;
              out_data_q <= sat_d;
              out_v_q    <= 1'b1;
              acc_q      <= '0;
              vec_cnt_q  <= '0;
              if (last_row) begin
                done_q    <= 1'b1;
                state_q   <= IDLE;
                row_cnt_q <= '0;
              end else begin
                row_cnt_q <= row_cnt_q + 8'd1;
              end
            end else begin
              acc_q     <= sum_d;
              vec_cnt_q <= vec_cnt_q + 5'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data = out_data_q;
  assign out_acc  = out_acc_q;
  assign out_v    = out_v_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_conv1_layer1_dense_addtree.sv
// Scoreboard bench for conv1_layer1_dense_addtree.
// Expected elements are queued at drive time, checked on out_v.
module tb_conv1_layer1_dense_addtree;

  localparam int NV = 4;
  localparam int NR = 8;
  localparam int AW = 41;
  localparam int FB = 8;

  typedef struct {
    longint acc;
    longint data;
    longint cyc;
    longint dn;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [799:0]   mult_res = '0;
  logic           mult_res_v = 1'b0;
  logic [15:0]    out_data;
  logic [AW-1:0]  out_acc;
  logic           out_v;
  logic           done;
  logic           busy;

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  exp_t   sb [$];

  bit     m_act = 0;
  int     m_vec = 0;
  int     m_row = 0;
  longint m_acc = 0;
  int     n_out = 0;
  bit     chk_busy = 0;

  conv1_layer1_dense_addtree #(
    .NUM_VEC(NV), .NUM_ROW(NR), .ACC_W(AW), .FRAC_BITS(FB)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mult_res(mult_res), .mult_res_v(mult_res_v),
    .out_data(out_data), .out_acc(out_acc), .out_v(out_v),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [799:0] fill(input int a, input int b);
    logic [799:0] v;
    for (int k = 0; k < 25; k++) v[32*k +: 32] = (k % 2 == 0) ? a : b;
    return v;
  endfunction

  function automatic logic [799:0] rnd();
    logic [799:0] v;
    for (int k = 0; k < 25; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic longint vsum(input logic [799:0] v);
    longint s = 0;
    logic signed [31:0] x;
    for (int k = 0; k < 25; k++) begin
      x = v[32*k +: 32];
      s += longint'(x);
    end
    return s;
  endfunction

  function automatic longint sat(input longint s);
    longint t = s >>> FB;
    if (t > 32767) return 32767;
    if (t < -32768) return -32768;
    return t;
  endfunction

  task automatic model_clear();
    m_vec = 0;
    m_row = 0;
    m_acc = 0;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    mult_res_v = 1'b0;
    m_act = 1;
    model_clear();
  endtask

  task automatic drive(input logic [799:0] v, input bit st);
    exp_t e;
    longint f;
    @(posedge clk); #1;
    mult_res = v;
    mult_res_v = 1'b1;
    start = st;
    if (st) begin
      m_act = 1;
      model_clear();
    end else if (m_act) begin
      m_acc += vsum(v);
      m_vec++;
      if (m_vec == NV) begin
        f = m_acc;
`ifdef CONV1_LAYER1_ADDTREE_RELU_EN
        if (f < 0) f = 0;
`endif
        e.acc = f;
        e.data = sat(f);
        e.cyc = cyc + 6;
        e.dn = (m_row == NR - 1) ? 1 : 0;
        sb.push_back(e);
        m_vec = 0;
        m_acc = 0;
        m_row++;
        if (m_row == NR) begin
          m_act = 0;
          m_row = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    mult_res_v = 1'b0;
    start = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_busy) begin
      check("busy_after_done", longint'(busy), 0);
      chk_busy = 0;
    end
    if (rst && out_v) begin
      n_out++;
      if (sb.size() == 0) begin
        check("spurious_out_v", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_acc", longint'($signed(out_acc)), e.acc);
        check("out_data", longint'($signed(out_data)), e.data);
        check("out_cycle", cyc, e.cyc);
        check("done", longint'(done), e.dn);
        if (done) chk_busy = 1;
      end
    end else if (rst && done) begin
      check("done_without_v", 1, 0);
    end
  end

  initial begin
    int n0;
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    #12;
    check("rst_data", longint'(out_data), 0);
    check("rst_acc", longint'(out_acc), 0);
    check("rst_v", longint'(out_v), 0);
    check("rst_done", longint'(done), 0);
    check("rst_busy", longint'(busy), 0);
    @(negedge clk);
    rst = 1'b1;

    do_start();
    for (int i = 0; i < NV; i++) drive(fill(256, 256), 0);
    idle(10);
    check("busy_run", longint'(busy), 1);

    for (int i = 0; i < NV; i++) drive(fill(1000, -1000), 0);
    idle(10);

    for (int i = 0; i < NV; i++) drive(fill(32'h80000000, 32'h80000000), 0);
    idle(10);

    do_start();
    n0 = n_out;
    for (int i = 0; i < NV * NR; i++) drive(rnd(), 0);
    idle(12);
    check("row_count", n_out - n0, NR);
    check("idle_after_run", longint'(busy), 0);

    drive(fill(5, 5), 0);
    idle(10);

    do_start();
    drive(rnd(), 0);
    drive(rnd(), 0);
    drive(fill(777, 777), 1);
    for (int i = 0; i < NV; i++) drive(rnd(), 0);
    idle(12);

    do_start();
    drive(rnd(), 0);
    drive(rnd(), 0);
    idle(2);
    #3;
    rst = 1'b0;
    m_act = 0;
    model_clear();
    #1;
    check("mid_rst_data", longint'(out_data), 0);
    check("mid_rst_acc", longint'(out_acc), 0);
    check("mid_rst_busy", longint'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    n0 = n_out;
    for (int i = 0; i < NV; i++) drive(rnd(), 0);
    idle(12);
    check("ignored_after_rst", n_out - n0, 0);
    check("ignored_busy", longint'(busy), 0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    check("drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv1_layer1_dense_addtree.md
Name: conv1_layer1_dense_addtree

Overview:
- Downstream of the conv1 layer1 25-lane 16x16 multiplier array.
- Takes each 800-bit product vector (25 signed 32-bit products) and reduces it through a pipelined adder tree.
- Accumulates NUM_VEC reduced sums into one output element, then rescales and saturates it to 16-bit fixed point.
- Emits one element per row and pulses done after NUM_ROW rows.

Parameters:
- NUM_VEC, 4: product vectors accumulated per output element (1..16).
- NUM_ROW, 8: output elements per run (1..255).
- ACC_W, 41: accumulator width in bits (37-bit tree sum plus 4 growth bits).
- FRAC_BITS, 8: arithmetic right shift applied before 16-bit saturation.

Ports:
- clk  in  1  clock; all registers on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run, clears accumulator and counters.
- mult_res  in  800  25 signed 32-bit products; lane k at [32k+31:32k].
- mult_res_v  in  1  one-cycle qualifier for mult_res.
- out_data  out  16  signed saturated result element.
- out_acc  out  ACC_W  unscaled accumulated sum, same cycle as out_data.
- out_v  out  1  one-cycle pulse, element valid.
- done  out  1  one-cycle pulse, coincident with the last out_v of a run.
- busy  out  1  high while in ACCUM.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; counters, pipeline valids and accumulator cleared.
- Output reset values: out_data=0, out_acc=0, out_v=0, done=0, busy=0.
- Adder tree:
  - 5 registered levels: 25→13→7→4→2→1; odd element passes through registered.
  - All additions signed, sign-extended, 1 bit growth per level; tree sum is 37 bits.
  - A valid bit travels with the data.
  - Fully pipelined: accepts mult_res_v every cycle.
- Latency: mult_res_v high in cycle T → tree sum registered at edge T+5 → accumulate at edge T+6.
  - For the final vector of a row, out_v is high in cycle T+6 (registered at edge T+6).
- State machine:
  - IDLE: busy=0. Input valids are dropped before entering the tree. start → ACCUM.
  - ACCUM: busy=1.
    - On each tree-valid: acc += sign_ext(tree_sum); vec_cnt++.
    - When vec_cnt==NUM_VEC-1 at a tree-valid:
      - out_acc = acc + tree_sum and out_v=1.
      - acc is cleared, vec_cnt=0, row_cnt++.
    - When that element is the final row (row_cnt==NUM_ROW-1): done=1, state → IDLE, row_cnt=0.
- Scaling: out_data = saturate16(final_sum >>> FRAC_BITS).
  - Above +32767 → 32767; below -32768 → -32768.
- start in ACCUM: restarts the run. acc, vec_cnt, row_cnt and all tree valid bits are flushed; no out_v is produced for the partial row.
- start and mult_res_v in the same cycle: start wins and that vector is dropped.
- Vectors arriving after done, while IDLE or in the tree, are discarded.
- Back-to-back rows: the tree-valid that completes row n and the next tree-valid (row n+1) are handled on consecutive cycles without loss, because the clear and the first add for the new row are merged (acc ← tree_sum).
- out_data and out_acc hold their last value when out_v=0.
- Reset mid-run aborts immediately; no out_v or done is emitted.

Optional Feature:
- Macro CONV1_LAYER1_ADDTREE_RELU_EN.
- Defined: ReLU is applied to the final sum before the shift; negative sums give out_data=0 and out_acc=0.
- Undefined: signed results pass unchanged (with saturation as above).
- Latency is identical in both builds.

Test Plan:
1. Reset, then start. NUM_VEC=4 vectors, all lanes = 256, one per cycle. Expect tree sum 6400 each, out_acc=25600, out_data=100, out_v 6 cycles after the 4th vector's mult_res_v.
2. Lanes alternating +1000/-1000 (lane 0 positive); 4 vectors. Expect out_acc=4000, out_data=15.
3. All lanes = -2^31; 4 vectors. Expect out_acc=-214748364800, out_data=-32768.
   - With RELU_EN defined: out_data=0.
4. NUM_ROW=8 rows × 4 vectors, valid every cycle.
   - Exactly 8 out_v pulses, 4 cycles apart.
   - done coincides with the 8th out_v; busy falls the next cycle.
5. start asserted after 2 vectors of a row, together with a third mult_res_v.
   - No out_v for that row; the third vector is dropped.
   - 4 fresh vectors produce a correct element.
6. rst pulsed low mid-row: all outputs read 0 immediately, busy=0, and mult_res_v is ignored until the next start.
